// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   Stage indices (IF..WB) used to address stall/flush vectors,
//   the scheduler state enum, exception code width and default
//   exception entry base.
package pipe_ctrl_pkg;

  localparam int unsigned ST_IF    = 0;
  localparam int unsigned ST_ID    = 1;
  localparam int unsigned ST_EX    = 2;
  localparam int unsigned ST_MEM   = 3;
  localparam int unsigned ST_WB    = 4;
  localparam int unsigned N_STAGES = 5;
  localparam int unsigned N_REQ    = 4;

  localparam int unsigned EXCP_CODE_W = 2;

  localparam logic [31:0] EXC_BASE_DEFAULT = 32'h0000_000c;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_REDIR
  } pipe_state_e;

endpackage

// File: rtl/stall_priority_enc.sv
// Stall priority encoder.
//   i_req   [3:0] : stall requests from IF, ID, EX, MEM
//   o_stall [4:0] : hold the input register of every stage up to and
//                   including the highest requesting stage
//   o_flush [4:0] : bubble into the stage just above the highest requester
module stall_priority_enc
  import pipe_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0]    i_req,
  output logic [N_STAGES-1:0] o_stall,
  output logic [N_STAGES-1:0] o_flush
);

  // Ascending scan: the last (highest) requesting stage overwrites lower ones.
  always_comb begin
    o_stall = '0;
    o_flush = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (i_req[k]) begin
        o_stall = '0;
        o_flush = '0;
        for (int unsigned j = 0; j <= k; j++) begin
          o_stall[j] = 1'b1;
        end
        o_flush[k+1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/redirect scheduler for the 5-stage pipeline.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stallreq_*_i        : per-stage stall requests (IF, ID, EX, MEM)
//   branch_taken_i/...  : EX redirect request and target
//   excp_*_i, ertn_i    : MEM-stage exception / exception return
//   mem_outstanding_i   : dcache transaction not yet acknowledged
//   stall_o, flush_o    : per-stage hold / bubble controls (bit 0 = IF)
//   redirect_valid_o/pc : PC mux load and target
//   epc_o, in_excp_o    : saved exception PC, handler-active flag
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 32,
  parameter logic [ADDR_W-1:0]  EXC_BASE       = ADDR_W'(EXC_BASE_DEFAULT),
  parameter int unsigned        REFILL_BUBBLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stallreq_if_i,
  input  logic                   stallreq_id_i,
  input  logic                   stallreq_ex_i,
  input  logic                   stallreq_mem_i,
  input  logic                   branch_taken_i,
  input  logic [ADDR_W-1:0]      branch_target_i,
  input  logic                   excp_valid_i,
  input  logic [EXCP_CODE_W-1:0] excp_code_i,
  input  logic [ADDR_W-1:0]      excp_pc_i,
  input  logic                   ertn_i,
  input  logic                   mem_outstanding_i,
  output logic [N_STAGES-1:0]    stall_o,
  output logic [N_STAGES-1:0]    flush_o,
  output logic                   redirect_valid_o,
  output logic [ADDR_W-1:0]      redirect_pc_o,
  output logic [ADDR_W-1:0]      epc_o,
  output logic                   in_excp_o
);

  pipe_state_e             r_state;
  pipe_state_e             w_state_nxt;
  logic [1:0]              r_bubble;
  logic [ADDR_W-1:0]       r_epc;
  logic [EXCP_CODE_W-1:0]  r_code;
  logic                    r_in_excp;

  logic [N_STAGES-1:0]     w_enc_stall;
  logic [N_STAGES-1:0]     w_enc_flush;
  logic                    w_excp_take;
  logic                    w_ertn_take;
  logic                    w_br_take;

  stall_priority_enc u_enc (
    .i_req   ({stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i}),
    .o_stall (w_enc_stall),
    .o_flush (w_enc_flush)
  );

  // Event decode in RUN; exception > ertn > branch. Exception/ertn wait
  // out a MEM stall, a branch also waits out an EX stall.
  always_comb begin
    w_excp_take = (r_state == S_RUN) && excp_valid_i && !stallreq_mem_i;
    w_ertn_take = (r_state == S_RUN) && ertn_i && !excp_valid_i && !stallreq_mem_i;
    w_br_take   = (r_state == S_RUN) && branch_taken_i && !excp_valid_i && !ertn_i
                  && !stallreq_mem_i && !stallreq_ex_i;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (w_excp_take) w_state_nxt = mem_outstanding_i ? S_DRAIN : S_REDIR;
      S_DRAIN: if (!mem_outstanding_i) w_state_nxt = S_REDIR;
      S_REDIR: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    stall_o          = '0;
    flush_o          = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    unique case (r_state)
      S_RUN: begin
        if (w_excp_take) begin
          flush_o[ST_WB:ST_ID] = '1;
        end else if (w_ertn_take) begin
          redirect_valid_o      = 1'b1;
          redirect_pc_o         = r_epc;
          flush_o[ST_MEM:ST_ID] = '1;
        end else if (w_br_take) begin
          redirect_valid_o     = 1'b1;
          redirect_pc_o        = branch_target_i;
          flush_o[ST_EX:ST_ID] = '1;
        end else begin
          stall_o = w_enc_stall;
          flush_o = w_enc_flush;
        end
        if (r_bubble != 2'd0) flush_o[ST_ID] = 1'b1;
      end
      S_DRAIN: stall_o = '1;
      S_REDIR: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = EXC_BASE + ADDR_W'({r_code, 2'b00});
        flush_o[ST_ID]   = 1'b1;
      end
      default: ;
    endcase
  end

  // Exception context and refill bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble  <= 2'd0;
      r_epc     <= '0;
      r_code    <= '0;
      r_in_excp <= 1'b0;
    end else begin
      if (w_excp_take) begin
        r_code <= excp_code_i;
        // A nested exception keeps the outer handler's return PC.
        if (!r_in_excp) r_epc <= excp_pc_i;
      end
      if (r_state == S_REDIR) r_in_excp <= 1'b1;
      else if (w_ertn_take)   r_in_excp <= 1'b0;

      if (w_br_take || w_ertn_take || r_state == S_REDIR)
        r_bubble <= 2'(REFILL_BUBBLES);
      else if (r_bubble != 2'd0)
        r_bubble <= r_bubble - 2'd1;
    end
  end

  assign epc_o     = r_epc;
  assign in_excp_o = r_in_excp;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        excp_valid_i;
  logic [1:0]  excp_code_i;
  logic [31:0] excp_pc_i;
  logic        ertn_i;
  logic        mem_outstanding_i;
  logic [4:0]  stall_o, flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o, epc_o;
  logic        in_excp_o;

  pipe_hazard_ctrl #(
    .ADDR_W         (32),
    .EXC_BASE       (32'h0000_000c),
    .REFILL_BUBBLES (1)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stallreq_if_i     (stallreq_if_i),
    .stallreq_id_i     (stallreq_id_i),
    .stallreq_ex_i     (stallreq_ex_i),
    .stallreq_mem_i    (stallreq_mem_i),
    .branch_taken_i    (branch_taken_i),
    .branch_target_i   (branch_target_i),
    .excp_valid_i      (excp_valid_i),
    .excp_code_i       (excp_code_i),
    .excp_pc_i         (excp_pc_i),
    .ertn_i            (ertn_i),
    .mem_outstanding_i (mem_outstanding_i),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o),
    .epc_o             (epc_o),
    .in_excp_o         (in_excp_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;   // {mem, ex, id, if}
    logic        br;
    logic [31:0] tgt;
    logic        exv;
    logic [1:0]  code;
    logic [31:0] xpc;
    logic        ertn;
    logic        outst;
  } in_t;

  typedef struct {
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic        inx;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic in_t inp(logic [3:0] req, logic br, logic [31:0] tgt, logic exv,
                              logic [1:0] code, logic [31:0] xpc, logic ertn, logic outst);
    in_t v;
    v.req = req; v.br = br; v.tgt = tgt; v.exv = exv;
    v.code = code; v.xpc = xpc; v.ertn = ertn; v.outst = outst;
    return v;
  endfunction

  function automatic exp_t ex(logic [4:0] s, logic [4:0] f, logic rv, logic [31:0] rpc,
                              logic [31:0] epc, logic inx);
    exp_t e;
    e.stall = s; e.flush = f; e.rv = rv; e.rpc = rpc; e.epc = epc; e.inx = inx;
    return e;
  endfunction

  function automatic in_t idle();
    return inp(4'b0000, 1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
  endfunction

  task automatic apply(input in_t v);
    stallreq_if_i     = v.req[0];
    stallreq_id_i     = v.req[1];
    stallreq_ex_i     = v.req[2];
    stallreq_mem_i    = v.req[3];
    branch_taken_i    = v.br;
    branch_target_i   = v.tgt;
    excp_valid_i      = v.exv;
    excp_code_i       = v.code;
    excp_pc_i         = v.xpc;
    ertn_i            = v.ertn;
    mem_outstanding_i = v.outst;
  endtask

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, req);
    end
  endtask

  task automatic check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty got=none want=entry", nm);
      return;
    end
    e = sb.pop_front();
    cmp(nm, "stall", 32'(stall_o), 32'(e.stall));
    cmp(nm, "flush", 32'(flush_o), 32'(e.flush));
    cmp(nm, "rv", 32'(redirect_valid_o), 32'(e.rv));
    cmp(nm, "rpc", redirect_pc_o, e.rpc);
    cmp(nm, "epc", epc_o, e.epc);
    cmp(nm, "inx", 32'(in_excp_o), 32'(e.inx));
  endtask

  // Drive one cycle of inputs just after the edge, check mid-cycle.
  task automatic step(input string nm, input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    apply(v);
    sb.push_back(e);
    @(negedge clk);
    check(nm);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{"none",     inp(4'b0000,0,0,0,0,0,0,0), ex(5'b00000,5'b00000,0,0,0,0)};
    tbl[1]  = '{"if",       inp(4'b0001,0,0,0,0,0,0,0), ex(5'b00001,5'b00010,0,0,0,0)};
    tbl[2]  = '{"id",       inp(4'b0010,0,0,0,0,0,0,0), ex(5'b00011,5'b00100,0,0,0,0)};
    tbl[3]  = '{"ex",       inp(4'b0100,0,0,0,0,0,0,0), ex(5'b00111,5'b01000,0,0,0,0)};
    tbl[4]  = '{"mem",      inp(4'b1000,0,0,0,0,0,0,0), ex(5'b01111,5'b10000,0,0,0,0)};
    tbl[5]  = '{"id_mem",   inp(4'b1010,0,0,0,0,0,0,0), ex(5'b01111,5'b10000,0,0,0,0)};
    tbl[6]  = '{"if_ex",    inp(4'b0101,0,0,0,0,0,0,0), ex(5'b00111,5'b01000,0,0,0,0)};
    tbl[7]  = '{"all",      inp(4'b1111,0,0,0,0,0,0,0), ex(5'b01111,5'b10000,0,0,0,0)};
    tbl[8]  = '{"ex_br",    inp(4'b0100,1,32'h500,0,0,0,0,0), ex(5'b00111,5'b01000,0,0,0,0)};
    tbl[9]  = '{"mem_excp", inp(4'b1000,0,0,1,2'd3,32'h70,0,1), ex(5'b01111,5'b10000,0,0,0,0)};
    tbl[10] = '{"mem_ertn", inp(4'b1000,0,0,0,0,0,1,0), ex(5'b01111,5'b10000,0,0,0,0)};

    rst_n = 1'b0;
    apply(idle());
    repeat (2) @(posedge clk);
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) step(tbl[i].name, tbl[i].i, tbl[i].e);

    // Branch with refill bubble
    step("br",    inp(4'b0000,1,32'h100,0,0,0,0,0), ex(0, 5'b00110, 1, 32'h100, 0, 0));
    step("br_b1", idle(),                            ex(0, 5'b00010, 0, 0, 0, 0));
    step("br_b0", idle(),                            ex(0, 5'b00000, 0, 0, 0, 0));

    // Branch while ID stalls, then a second branch reloads the bubble
    step("br_id",  inp(4'b0010,1,32'h140,0,0,0,0,0), ex(0, 5'b00110, 1, 32'h140, 0, 0));
    step("br_rl",  inp(4'b0000,1,32'h180,0,0,0,0,0), ex(0, 5'b00110, 1, 32'h180, 0, 0));
    step("rl_b1",  idle(),                            ex(0, 5'b00010, 0, 0, 0, 0));
    step("rl_b0",  idle(),                            ex(0, 5'b00000, 0, 0, 0, 0));

    // Exception with simultaneous branch, 3-cycle drain
    step("exc",    inp(4'b0000,1,32'h200,1,2'd2,32'h40,0,1), ex(0, 5'b11110, 0, 0, 0, 0));
    step("drain1", inp(4'b0110,1,32'h200,0,0,0,0,1),         ex(5'b11111, 0, 0, 0, 32'h40, 0));
    step("drain2", inp(4'b0000,0,0,0,0,0,1,1),               ex(5'b11111, 0, 0, 0, 32'h40, 0));
    step("drain3", idle(),                                    ex(5'b11111, 0, 0, 0, 32'h40, 0));
    step("redir",  idle(),                  ex(0, 5'b00010, 1, 32'h14, 32'h40, 0));
    step("ent_b1", idle(),                  ex(0, 5'b00010, 0, 0, 32'h40, 1));
    step("ent_b0", idle(),                  ex(0, 5'b00000, 0, 0, 32'h40, 1));

    // Nested exception keeps epc
    step("nest",   inp(4'b0000,0,0,1,2'd1,32'h80,0,0), ex(0, 5'b11110, 0, 0, 32'h40, 1));
    step("n_redir",idle(),                  ex(0, 5'b00010, 1, 32'h10, 32'h40, 1));
    step("n_b1",   idle(),                  ex(0, 5'b00010, 0, 0, 32'h40, 1));

    // ertn returns to epc
    step("ertn",   inp(4'b0000,0,0,0,0,0,1,0), ex(0, 5'b01110, 1, 32'h40, 32'h40, 1));
    step("ert_b1", idle(),                     ex(0, 5'b00010, 0, 0, 32'h40, 0));
    step("ert_b0", idle(),                     ex(0, 5'b00000, 0, 0, 32'h40, 0));

    // ertn outside a handler, racing a branch
    step("ertn_br",inp(4'b0000,1,32'h300,0,0,0,1,0), ex(0, 5'b01110, 1, 32'h40, 32'h40, 0));
    step("eb_b1",  idle(),                            ex(0, 5'b00010, 0, 0, 32'h40, 0));

    // Exception held off by MEM stall, taken once released
    step("exc_hold", inp(4'b1000,0,0,1,2'd3,32'h60,0,0), ex(5'b01111, 5'b10000, 0, 0, 32'h40, 0));
    step("exc_go",   inp(4'b0000,0,0,1,2'd3,32'h60,0,0), ex(0, 5'b11110, 0, 0, 32'h40, 0));
    step("go_redir", idle(),                  ex(0, 5'b00010, 1, 32'h18, 32'h60, 0));
    step("go_b1",    idle(),                  ex(0, 5'b00010, 0, 0, 32'h60, 1));

    // Reset during DRAIN
    step("exc_d",  inp(4'b0000,0,0,1,2'd0,32'h90,0,1), ex(0, 5'b11110, 0, 0, 32'h60, 1));
    step("drn_d",  inp(4'b0000,0,0,0,0,0,0,1),         ex(5'b11111, 0, 0, 0, 32'h60, 1));
    @(posedge clk);
    #1;
    apply(idle());
    rst_n = 1'b0;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_drain");
    rst_n = 1'b1;
    step("post_rst1", idle(), ex(0, 0, 0, 0, 0, 0));
    step("post_rst2", idle(), ex(0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
